// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell codes, FSM state encoding and win-line table for the tic-tac-toe controller
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_X    = 3'd1,
        ST_WAIT_O    = 3'd2,
        ST_CHECK     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    // Cell indices are 0-based, row-major (index 0 = pos1, index 8 = pos9).
    localparam int NUM_LINES = 8;
    localparam int LINE_TBL [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic pos_valid(input logic [3:0] pos);
        return (pos >= 4'd1) && (pos <= 4'd9);
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// rtl/ttt_line_check.sv - combinational detector for three equal non-empty cells on any of the 8 lines
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] cells,
    output logic        line_found,
    output logic [1:0]  line_owner
);

    logic [1:0] cell_a;
    logic [1:0] cell_b;
    logic [1:0] cell_c;

    // Scan every line; a completed line reports the code that fills it.
    always_comb begin
        line_found = 1'b0;
        line_owner = CELL_EMPTY;
        cell_a     = CELL_EMPTY;
        cell_b     = CELL_EMPTY;
        cell_c     = CELL_EMPTY;
        for (int l = 0; l < NUM_LINES; l++) begin
            cell_a = cells[2*LINE_TBL[l][0] +: 2];
            cell_b = cells[2*LINE_TBL[l][1] +: 2];
            cell_c = cells[2*LINE_TBL[l][2] +: 2];
            if ((cell_a != CELL_EMPTY) && (cell_a == cell_b) && (cell_b == cell_c)) begin
                line_found = 1'b1;
                line_owner = cell_a;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe game controller: turn FSM, board registers, move validation, turn timeout
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       new_game,
    input  logic       req_x,
    input  logic       req_o,
    input  logic [3:0] pos_x,
    input  logic [3:0] pos_o,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       turn,
    output logic       won,
    output logic [1:0] winner,
    output logic       draw,
    output logic       illegal,
    output logic [2:0] state
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  board_q [0:8];
    logic [3:0]  move_cnt_q;
    logic [15:0] timer_q;
    logic        won_q;
    logic [1:0]  winner_q;
    logic        draw_q;
    logic        illegal_q;
    logic        mover_o_q;

    logic        on_req;
    logic [3:0]  on_pos;
    logic        off_req;
    logic [3:0]  cell_idx;
    logic [1:0]  mover_code;
    logic        accept;
    logic        reject;
    logic        win_set;
    logic [1:0]  win_code;
    logic        draw_set;
    logic        clear_game;
    logic        enter_wait;

    logic [17:0] board_flat;
    logic        line_found;
    logic [1:0]  line_owner;

    // Flatten the registered board for the line checker (pos1 in the low bits).
    always_comb begin
        board_flat = '0;
        for (int k = 0; k < 9; k++) begin
            board_flat[2*k +: 2] = board_q[k];
        end
    end

    ttt_line_check u_line_check (
        .cells      (board_flat),
        .line_found (line_found),
        .line_owner (line_owner)
    );

    // Next-state logic plus move validation, timeout and end-of-game decisions.
    always_comb begin
        state_d    = state_q;
        on_req     = 1'b0;
        on_pos     = 4'd0;
        off_req    = 1'b0;
        mover_code = CELL_X;
        accept     = 1'b0;
        reject     = 1'b0;
        win_set    = 1'b0;
        win_code   = CELL_EMPTY;
        draw_set   = 1'b0;
        clear_game = 1'b0;

        if (state_q == ST_WAIT_O) begin
            on_req     = req_o;
            on_pos     = pos_o;
            off_req    = req_x;
            mover_code = CELL_O;
        end else begin
            on_req     = req_x;
            on_pos     = pos_x;
            off_req    = req_o;
            mover_code = CELL_X;
        end
        cell_idx = pos_valid(on_pos) ? (on_pos - 4'd1) : 4'd0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT_X;
                    clear_game = 1'b1;
                end
            end
            ST_WAIT_X, ST_WAIT_O: begin
                if (on_req && pos_valid(on_pos) && (board_q[cell_idx] == CELL_EMPTY)) begin
                    accept = 1'b1;
                end else if (on_req) begin
                    reject = 1'b1;
                end
                if (off_req) begin
                    reject = 1'b1;
                end
                if (accept) begin
                    state_d = ST_CHECK;
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = ST_GAME_OVER;
                    win_set  = 1'b1;
                    win_code = (state_q == ST_WAIT_X) ? CELL_O : CELL_X;
                end
            end
            ST_CHECK: begin
                if (line_found) begin
                    state_d  = ST_GAME_OVER;
                    win_set  = 1'b1;
                    win_code = mover_o_q ? CELL_O : CELL_X;
                end else if (move_cnt_q == 4'd9) begin
                    state_d  = ST_GAME_OVER;
                    draw_set = 1'b1;
                end else begin
                    state_d = mover_o_q ? ST_WAIT_X : ST_WAIT_O;
                end
            end
            ST_GAME_OVER: begin
                if (new_game) begin
                    state_d    = ST_WAIT_X;
                    clear_game = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        enter_wait = ((state_d == ST_WAIT_X) || (state_d == ST_WAIT_O)) && (state_d != state_q);
    end

    // State, board, counters and result flags; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            for (int k = 0; k < 9; k++) begin
                board_q[k] <= CELL_EMPTY;
            end
            move_cnt_q <= 4'd0;
            timer_q    <= 16'd0;
            won_q      <= 1'b0;
            winner_q   <= CELL_EMPTY;
            draw_q     <= 1'b0;
            illegal_q  <= 1'b0;
            mover_o_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= reject;

            if (clear_game) begin
                for (int k = 0; k < 9; k++) begin
                    board_q[k] <= CELL_EMPTY;
                end
                move_cnt_q <= 4'd0;
                won_q      <= 1'b0;
                winner_q   <= CELL_EMPTY;
                draw_q     <= 1'b0;
            end

            if (accept) begin
                board_q[cell_idx] <= mover_code;
                mover_o_q         <= (state_q == ST_WAIT_O);
                if (move_cnt_q != 4'd9) begin
                    move_cnt_q <= move_cnt_q + 4'd1;
                end
            end

            if (win_set) begin
                won_q    <= 1'b1;
                winner_q <= win_code;
            end
            if (draw_set) begin
                draw_q <= 1'b1;
            end

            // A rejected request does not restart the turn timer.
            if (enter_wait) begin
                timer_q <= 16'd0;
            end else if ((state_q == ST_WAIT_X) || (state_q == ST_WAIT_O)) begin
                timer_q <= timer_q + 16'd1;
            end
        end
    end

    assign pos1    = board_q[0];
    assign pos2    = board_q[1];
    assign pos3    = board_q[2];
    assign pos4    = board_q[3];
    assign pos5    = board_q[4];
    assign pos6    = board_q[5];
    assign pos7    = board_q[6];
    assign pos8    = board_q[7];
    assign pos9    = board_q[8];
    assign turn    = (state_q == ST_WAIT_O);
    assign won     = won_q;
    assign winner  = winner_q;
    assign draw    = draw_q;
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - scoreboard bench for ttt_game_ctrl with a 4-cycle turn timeout
module tb_ttt_game_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WX   = 3'd1;
    localparam logic [2:0] S_WO   = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_GO   = 3'd4;
    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;

    logic       clk = 1'b0;
    logic       reset, start, new_game, req_x, req_o;
    logic [3:0] pos_x, pos_o;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       turn, won, draw, illegal;
    logic [1:0] winner;
    logic [2:0] state;

    ttt_game_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .new_game(new_game),
        .req_x(req_x), .req_o(req_o), .pos_x(pos_x), .pos_o(pos_o),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .turn(turn), .won(won), .winner(winner), .draw(draw),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Packed observation: {state, illegal, won, winner, draw, turn, pos9..pos1}
    typedef struct {
        string       name;
        logic [26:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [26:0] got_q[$];
    logic [1:0]  mb [9];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        for (int k = 0; k < 9; k++) b[2*k +: 2] = mb[k];
        return b;
    endfunction

    task automatic clear_mb();
        for (int k = 0; k < 9; k++) mb[k] = E;
    endtask

    // Drive one cycle, push the expected post-edge observation, capture the DUT after the edge.
    task automatic cyc(input string nm, input logic rs, input logic s, input logic ng,
                       input logic rx, input logic [3:0] px, input logic ro, input logic [3:0] po,
                       input logic [2:0] est, input logic eill, input logic ewon,
                       input logic [1:0] ewin, input logic edraw);
        exp_t e;
        logic t;
        reset = rs; start = s; new_game = ng;
        req_x = rx; pos_x = px; req_o = ro; pos_o = po;
        e.name = nm;
        e.v = {est, eill, ewon, ewin, edraw, (est == S_WO), model_board()};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        // turn only carries meaning while waiting for a move (and at reset)
        t = ((state == S_WX) || (state == S_WO) || (state == S_IDLE)) ? turn : (est == S_WO);
        got_q.push_back({state, illegal, won, winner, draw, t,
                         pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1});
        reset = 1'b0; start = 1'b0; new_game = 1'b0;
        req_x = 1'b0; req_o = 1'b0; pos_x = 4'd0; pos_o = 4'd0;
    endtask

    task automatic go(input string nm, input logic [2:0] est, input logic ewon = 1'b0,
                      input logic [1:0] ewin = 2'b00, input logic edraw = 1'b0);
        cyc(nm, 0, 0, 0, 0, 4'd0, 0, 4'd0, est, 0, ewon, ewin, edraw);
    endtask

    task automatic test_reset();
        exp_t e; logic [26:0] g;
        clear_mb();
        cyc("reset_with_start", 1, 1, 0, 1, 4'd5, 0, 4'd0, S_IDLE, 0, 0, E, 0);
        cyc("reset_hold", 1, 0, 0, 0, 4'd0, 0, 4'd0, S_IDLE, 0, 0, E, 0);
        cyc("idle_req_ignored", 0, 0, 0, 1, 4'd5, 1, 4'd3, S_IDLE, 0, 0, E, 0);
        cyc("idle_new_game_ignored", 0, 0, 1, 0, 4'd0, 0, 4'd0, S_IDLE, 0, 0, E, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e.v) begin
                n_bad++;
                $display("FAIL %s: observed %h required %h", e.name, g, e.v);
            end
        end
    endtask

    task automatic test_x_win();
        exp_t e; logic [26:0] g;
        int tbl [5] = '{1, 4, 2, 5, 3};
        clear_mb();
        cyc("start", 0, 1, 0, 0, 4'd0, 0, 4'd0, S_WX, 0, 0, E, 0);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                mb[tbl[i]-1] = X;
                cyc($sformatf("win_mv%0d", i), 0, 0, 0, 1, 4'(tbl[i]), 0, 4'd0, S_CHK, 0, 0, E, 0);
            end else begin
                mb[tbl[i]-1] = O;
                cyc($sformatf("win_mv%0d", i), 0, 0, 0, 0, 4'd0, 1, 4'(tbl[i]), S_CHK, 0, 0, E, 0);
            end
            if (i < 4) go($sformatf("win_chk%0d", i), (i % 2 == 0) ? S_WO : S_WX);
            else       go("win_x_row", S_GO, 1, X);
        end
        cyc("over_req_ignored", 0, 0, 0, 1, 4'd7, 1, 4'd8, S_GO, 0, 1, X, 0);
        cyc("over_start_ignored", 0, 1, 0, 0, 4'd0, 0, 4'd0, S_GO, 0, 1, X, 0);
        clear_mb();
        cyc("new_game_clears", 0, 0, 1, 0, 4'd0, 0, 4'd0, S_WX, 0, 0, E, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e.v) begin
                n_bad++;
                $display("FAIL %s: observed %h required %h", e.name, g, e.v);
            end
        end
    endtask

    task automatic test_draw();
        exp_t e; logic [26:0] g;
        int tbl [9] = '{5, 1, 9, 7, 4, 6, 3, 2, 8};
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) begin
                mb[tbl[i]-1] = X;
                cyc($sformatf("draw_mv%0d", i), 0, 0, 0, 1, 4'(tbl[i]), 0, 4'd0, S_CHK, 0, 0, E, 0);
            end else begin
                mb[tbl[i]-1] = O;
                cyc($sformatf("draw_mv%0d", i), 0, 0, 0, 0, 4'd0, 1, 4'(tbl[i]), S_CHK, 0, 0, E, 0);
            end
            if (i < 8) go($sformatf("draw_chk%0d", i), (i % 2 == 0) ? S_WO : S_WX);
            else       go("draw_full_board", S_GO, 0, E, 1);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e.v) begin
                n_bad++;
                $display("FAIL %s: observed %h required %h", e.name, g, e.v);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e; logic [26:0] g;
        clear_mb();
        cyc("ill_new_game", 0, 0, 1, 0, 4'd0, 0, 4'd0, S_WX, 0, 0, E, 0);
        cyc("ill_off_turn", 0, 0, 0, 0, 4'd0, 1, 4'd3, S_WX, 1, 0, E, 0);
        cyc("ill_pos12", 0, 0, 0, 1, 4'd12, 0, 4'd0, S_WX, 1, 0, E, 0);
        go("ill_pulse_ends", S_WX);
        go("ill_timer_kept", S_GO, 1, O);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e.v) begin
                n_bad++;
                $display("FAIL %s: observed %h required %h", e.name, g, e.v);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e; logic [26:0] g;
        clear_mb();
        cyc("to_new_game", 0, 0, 1, 0, 4'd0, 0, 4'd0, S_WX, 0, 0, E, 0);
        for (int i = 1; i <= 3; i++) go($sformatf("to_x_wait%0d", i), S_WX);
        go("to_x_expire", S_GO, 1, O);
        clear_mb();
        cyc("to_new_game2", 0, 0, 1, 0, 4'd0, 0, 4'd0, S_WX, 0, 0, E, 0);
        mb[0] = X;
        cyc("to_x_pos1", 0, 0, 0, 1, 4'd1, 0, 4'd0, S_CHK, 0, 0, E, 0);
        go("to_to_o", S_WO);
        for (int i = 1; i <= 3; i++) go($sformatf("to_o_wait%0d", i), S_WO);
        go("to_o_expire", S_GO, 1, X);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e.v) begin
                n_bad++;
                $display("FAIL %s: observed %h required %h", e.name, g, e.v);
            end
        end
    endtask

    task automatic test_occupied();
        exp_t e; logic [26:0] g;
        clear_mb();
        cyc("occ_new_game", 0, 0, 1, 0, 4'd0, 0, 4'd0, S_WX, 0, 0, E, 0);
        mb[4] = X;
        cyc("occ_x5", 0, 0, 0, 1, 4'd5, 0, 4'd0, S_CHK, 0, 0, E, 0);
        go("occ_to_o", S_WO);
        cyc("occ_o5_rejected", 0, 0, 0, 0, 4'd0, 1, 4'd5, S_WO, 1, 0, E, 0);
        go("occ_wait1", S_WO);
        go("occ_wait2", S_WO);
        mb[0] = O;
        cyc("occ_accept_at_expiry", 0, 0, 0, 0, 4'd0, 1, 4'd1, S_CHK, 0, 0, E, 0);
        go("occ_back_to_x", S_WX);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e.v) begin
                n_bad++;
                $display("FAIL %s: observed %h required %h", e.name, g, e.v);
            end
        end
    endtask

    task automatic test_reset_in_check();
        exp_t e; logic [26:0] g;
        mb[8] = X;
        cyc("ric_x9", 0, 0, 0, 1, 4'd9, 0, 4'd0, S_CHK, 0, 0, E, 0);
        clear_mb();
        cyc("ric_reset", 1, 0, 0, 1, 4'd2, 1, 4'd3, S_IDLE, 0, 0, E, 0);
        cyc("ric_new_game_ignored", 0, 0, 1, 0, 4'd0, 0, 4'd0, S_IDLE, 0, 0, E, 0);
        cyc("ric_start", 0, 1, 0, 0, 4'd0, 0, 4'd0, S_WX, 0, 0, E, 0);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e.v) begin
                n_bad++;
                $display("FAIL %s: observed %h required %h", e.name, g, e.v);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; new_game = 1'b0;
        req_x = 1'b0; req_o = 1'b0; pos_x = 4'd0; pos_o = 4'd0;
        clear_mb();
        test_reset();
        test_x_win();
        test_draw();
        test_illegal();
        test_timeout();
        test_occupied();
        test_reset_in_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, idle cycles allowed per turn before forfeit; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; leaves IDLE and begins a game with X to move.
REQ-005 new_game  input  1  one-cycle pulse; from GAME_OVER only, clears board, X to move.
REQ-006 req_x / req_o  input  1 each  move request from player X / player O, sampled each cycle.
REQ-007 pos_x / pos_o  input  4 each  requested cell 1..9 (row-major: 1-3 top, 7-9 bottom).
REQ-008 pos1..pos9  output  2 each  board cells, registered; 00 empty, 01 X, 10 O, 11 never driven.
REQ-009 turn  output  1  0 = X to move, 1 = O to move; meaningful in WAIT_X/WAIT_O only.
REQ-010 won / winner  output  1 / 2  game won; winner 01 X, 10 O, 00 when won=0.
REQ-011 draw  output  1  board full (9 moves) with no line complete.
REQ-012 illegal  output  1  one-cycle pulse flagging a rejected move request.
REQ-013 state  output  3  current FSM state encoding, for debug/display.

Function
REQ-014 FSM states: IDLE, WAIT_X, WAIT_O, CHECK, GAME_OVER; exactly one active per cycle.
REQ-015 IDLE -> WAIT_X on start; other inputs ignored in IDLE, illegal stays 0.
REQ-016 WAIT_X accepts a move when req_x=1, pos_x in 1..9, target cell 00; cell written 01 at the edge ending that cycle, next state CHECK.
REQ-017 WAIT_O identical with req_o/pos_o, cell written 10.
REQ-018 Request from the off-turn player: ignored, illegal pulses next cycle, no state change.
REQ-019 On-turn request with pos 0 or 10..15, or occupied cell: rejected, illegal pulses next cycle, same player keeps turn, turn timer not reset.
REQ-020 Both req_x and req_o high same cycle: on-turn request handled per REQ-016/017/019; off-turn request ignored; illegal pulses if either was rejected.
REQ-021 CHECK lasts exactly one cycle; evaluates all 8 lines (3 rows, 3 cols, 2 diagonals) of the already-updated registered board.
REQ-022 CHECK -> GAME_OVER with won=1, winner = mover's code if any line holds three equal non-empty cells.
REQ-023 Else CHECK -> GAME_OVER with draw=1 if move count = 9.
REQ-024 Else CHECK -> WAIT_O after an X move, WAIT_X after an O move.
REQ-025 Latency: move accepted in cycle N -> board visible N+1 -> won/draw asserted from N+2.
REQ-026 Move counter 4 bits, increments once per accepted move, saturates at 9, cleared on new_game/start/reset.
REQ-027 Turn timer counts cycles in WAIT_X/WAIT_O, cleared on entering either; at TIMEOUT_CYCLES-1 without acceptance -> GAME_OVER, won=1, winner = opponent.
REQ-028 Accepted move in the expiry cycle takes precedence over timeout.
REQ-029 GAME_OVER holds board, won, winner, draw stable; move requests ignored without illegal; new_game -> WAIT_X with board, counters, won, winner, draw cleared.
REQ-030 start outside IDLE and new_game outside GAME_OVER have no effect.
REQ-031 won and draw never both 1.

Reset
REQ-032 reset, sampled on clk edge, forces state IDLE, all pos* 00, turn 0, won 0, winner 00, draw 0, illegal 0, counters 0.
REQ-033 reset overrides all other inputs in the same cycle, including mid-game and during CHECK.

Structure
REQ-034 Shared package holds cell codes (EMPTY 00, X 01, O 10), FSM state encoding, and line index table.
REQ-035 One combinational sub-module, ttt_line_check: nine 2-bit cells in, line_found and line_owner out; instanced once on the registered board.
REQ-036 Board is nine 2-bit registers owned solely by ttt_game_ctrl; no other writer.

Verification
REQ-037 reset, start; X moves 1, O 4, X 2, O 5, X 3 -> won=1, winner=01 two cycles after X@3 acceptance, pos1..3 = 01.
REQ-038 Sequence X5,O1,X9,O7,X4,O6,X3,O2,X8 -> draw=1, won=0 after 9th move, count=9.
REQ-039 In WAIT_X: req_o pos 3, then req_x pos 12 -> two illegal pulses, board unchanged, state stays WAIT_X.
REQ-040 X plays 5; O requests 5 -> illegal pulse, pos5 stays 01, turn stays 1.
REQ-041 TIMEOUT_CYCLES=4, no request in WAIT_X -> GAME_OVER on 4th cycle, winner=10.
REQ-042 reset asserted in CHECK after X move -> next cycle IDLE, all outputs at reset values; new_game in IDLE ignored.
